// File: rtl/vga_frame_sched_pkg.sv
// Shared FSM state type, default geometry and test-pattern packing for vga_frame_sched.
// Pure declarations: no latency, no flow control.
package vga_frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_ACT,
    S_HBLK,
    S_VBLK
  } state_t;

  localparam int DEF_H_ACT   = 16;
  localparam int DEF_V_ACT   = 16;
  localparam int DEF_H_BLANK = 8;
  localparam int DEF_V_BLANK = 4;

  localparam int LINE_LEN  = DEF_H_ACT + DEF_H_BLANK;
  localparam int FRAME_PIX = DEF_H_ACT * DEF_V_ACT;
  localparam int VBLK_LEN  = DEF_V_BLANK * LINE_LEN;

  function automatic logic [31:0] pack_pat(input logic [7:0] f, input logic [7:0] y,
                                           input logic [7:0] x);
    return {8'h00, f, y, x};
  endfunction

endpackage

// File: rtl/vga_sched_delay.sv
// Fixed-depth shift register used to align frame/pixel strobes with memory read data.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module vga_sched_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = d;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_sched.sv
// Frame scheduler: reads pixels through a fixed-latency port and emits vga_vs/vga_de/vga_data frames.
// start->vga_vs is RD_LAT+2 cycles, no backpressure; VGA_FRAME_SCHED_TESTPAT_EN adds a pat_en test pattern.
import vga_frame_sched_pkg::*;

module vga_frame_sched #(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int H_BLANK = DEF_H_BLANK,
  parameter int V_BLANK = DEF_V_BLANK,
  parameter int RD_LAT  = 2,
  parameter int ADDR_W  = $clog2(FRAME_PIX),
  parameter int FRAME_W = 8
) (
  input  logic               vga_clk,
  input  logic               vga_rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [FRAME_W-1:0] num_frames,
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
  input  logic               pat_en,
`endif
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [31:0]        rd_data,
  output logic               vga_vs,
  output logic               vga_de,
  output logic [31:0]        vga_data
);

  localparam int LINE  = H_ACT + H_BLANK;
  localparam int VBLK  = V_BLANK * LINE;
  localparam int X_W   = $clog2(H_ACT + 1);
  localparam int Y_W   = $clog2(V_ACT + 1);
  localparam int CNT_W = $clog2(VBLK + RD_LAT + H_BLANK + 1);

  state_t             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] num_q, num_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               vs_q, vs_d;
  logic [31:0]        data_q, data_d;
  logic               ended;

`ifdef VGA_FRAME_SCHED_TESTPAT_EN
  logic               pat_q, pat_d;
  logic [31:0]        pat_now, pat_dly;

  assign pat_now = pack_pat(8'(frame_q), 8'(y_q), 8'(x_q));

  vga_sched_delay #(.W(32), .DEPTH(RD_LAT)) u_pat_dly (
    .clk   (vga_clk),
    .rst_n (vga_rst_n),
    .d     (pat_now),
    .q     (pat_dly)
  );
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    frame_d = frame_q;
    num_d   = num_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = rd_data;
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
    pat_d   = pat_q;
    if (pat_q) data_d = pat_dly;
`endif
    // A stop seen on the deciding VBLK cycle ends the run there, same as a latched one.
    ended = stop_q || stop || ((num_q != '0) && (frame_q == num_q));
    if ((state_q != S_IDLE) && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_OPEN;
          busy_d  = 1'b1;
          frame_d = '0;
          stop_d  = 1'b0;
          num_d   = num_frames;
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
          pat_d   = pat_en;
`endif
        end
      end
      S_OPEN: begin
        state_d = S_ACT;
        x_d     = '0;
        y_d     = '0;
      end
      S_ACT: begin
        addr_d = addr_q + ADDR_W'(1);
        if (x_q == X_W'(H_ACT - 1)) begin
          state_d = S_HBLK;
          cnt_d   = '0;
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
      S_HBLK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (y_q == Y_W'(V_ACT - 1)) begin
            state_d = S_VBLK;
            frame_d = frame_q + FRAME_W'(1);
          end else begin
            state_d = S_ACT;
            x_d     = '0;
            y_d     = y_q + Y_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VBLK: begin
        // An ending run stays here RD_LAT extra cycles so the delay line drains before done.
        if ((cnt_q == CNT_W'(VBLK - 1)) && !ended) begin
          state_d = S_OPEN;
        end else if (cnt_q == CNT_W'(VBLK - 1 + RD_LAT)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_OPEN) addr_d = '0;
    rd_en_d = (state_d == S_ACT);
    vs_d    = (state_d == S_OPEN) || (state_d == S_ACT) || (state_d == S_HBLK);
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      frame_q <= '0;
      num_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      vs_q    <= 1'b0;
      data_q  <= '0;
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
      pat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      num_q   <= num_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      vs_q    <= vs_d;
      data_q  <= data_d;
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
      pat_q   <= pat_d;
`endif
    end
  end

  // vga_data_q adds the final stage, so the strobes need RD_LAT+1 to line up with it.
  vga_sched_delay #(.W(2), .DEPTH(RD_LAT + 1)) u_strobe_dly (
    .clk   (vga_clk),
    .rst_n (vga_rst_n),
    .d     ({vs_q, rd_en_q}),
    .q     ({vga_vs, vga_de})
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = addr_q;
  assign vga_data  = data_q;

endmodule

// File: tb/tb_vga_frame_sched.sv
// Directed bench for vga_frame_sched at default geometry (16x16, blanks 8/4, RD_LAT 2).
// Memory model returns rd_data = rd_addr two cycles after the address is presented.
module tb_vga_frame_sched;

  logic        vga_clk = 1'b0;
  logic        vga_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  num_frames = 8'd0;
  logic        busy, done, rd_en, vga_vs, vga_de;
  logic [7:0]  frame_cnt, rd_addr;
  logic [31:0] rd_data, vga_data;
  logic        mem_x = 1'b0;
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
  logic        pat_en = 1'b0;
`endif

  vga_frame_sched dut (
    .vga_clk    (vga_clk),
    .vga_rst_n  (vga_rst_n),
    .start      (start),
    .stop       (stop),
    .num_frames (num_frames),
`ifdef VGA_FRAME_SCHED_TESTPAT_EN
    .pat_en     (pat_en),
`endif
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .vga_vs     (vga_vs),
    .vga_de     (vga_de),
    .vga_data   (vga_data)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  logic [7:0] a1 = 8'd0, a2 = 8'd0;
  always @(posedge vga_clk) begin
    a1 <= rd_addr;
    a2 <= a1;
  end
  assign rd_data = mem_x ? 32'hxxxx_xxxx : {24'h0, a2};

  // Stream monitor; cleared whenever clr_gen is bumped.
  int clr_gen = 0, clr_seen = 0;
  int n_rise, n_fall, n_de, pix, t_rise, t_fall, first_rise, first_de;
  int hi_bad, lo_bad, lo_n, de_bad, pix_bad, rise_de_bad, n_done, done_cyc;
  logic busy_at_done, prev_vs;
  logic [31:0] cap_pix;

  always @(negedge vga_clk) begin
    if (clr_seen != clr_gen) begin
      clr_seen = clr_gen;
      n_rise = 0; n_fall = 0; n_de = 0; pix = 0; t_rise = 0; t_fall = 0;
      first_rise = -1; first_de = -1; hi_bad = 0; lo_bad = 0; lo_n = 0;
      de_bad = 0; pix_bad = 0; rise_de_bad = 0; n_done = 0; done_cyc = -1;
      busy_at_done = 1'b1; cap_pix = 32'hdead_beef; prev_vs = vga_vs;
    end else begin
      if (vga_vs && !prev_vs) begin
        if (n_rise == 0) first_rise = cyc;
        if (n_fall > 0) begin
          lo_n++;
          if (cyc - t_fall != 96) lo_bad++;
        end
        if (vga_de) rise_de_bad++;
        n_rise++; t_rise = cyc; pix = 0;
      end
      if (!vga_vs && prev_vs) begin
        n_fall++; t_fall = cyc;
        if (cyc - t_rise != 385) hi_bad++;
        if (pix != 256) pix_bad++;
      end
      if (vga_de) begin
        if (first_de < 0) first_de = cyc;
        if (cyc != t_rise + 1 + (pix / 16) * 24 + (pix % 16) || vga_data !== 32'(pix)) de_bad++;
        if (n_rise == 2 && pix == 115) cap_pix = vga_data;
        n_de++; pix++;
      end
      if (done) begin
        n_done++; done_cyc = cyc; busy_at_done = busy;
      end
      prev_vs = vga_vs;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] nf, output int t);
    @(posedge vga_clk); #1;
    num_frames = nf; start = 1'b1; t = cyc;
    @(posedge vga_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin
      step(1);
      k++;
    end
    chk_eq("done_seen", done, 1);
  endtask

  task automatic clr_mon();
    clr_gen++;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;

    step(3);
    chk_eq("rst_strobes", {busy, done, rd_en, vga_vs, vga_de}, 0);
    chk_eq("rst_frame_cnt", frame_cnt, 0);
    chk_eq("rst_rd_addr", rd_addr, 0);
    chk_eq("rst_vga_data", vga_data, 0);
    vga_rst_n = 1'b1;
    step(2);

    // Single frame: latency, pixel order and gaps, done timing.
    clr_mon();
    kick(8'd1, t);
    chk_eq("t1_busy", busy, 1);
    chk_eq("t1_rd_en_early", rd_en, 0);
    step(1);
    chk_eq("t2_rd_en", rd_en, 1);
    chk_eq("t2_rd_addr", rd_addr, 0);
    wait_done(600);
    step(2);
    chk_eq("one_vs_rise", 64'(first_rise - t), 4);
    chk_eq("one_first_de", 64'(first_de - t), 5);
    chk_eq("one_de_count", n_de, 256);
    chk_eq("one_de_bad", de_bad, 0);
    chk_eq("one_rise_de", rise_de_bad, 0);
    chk_eq("one_frame_cnt", frame_cnt, 1);
    chk_eq("one_done_cnt", n_done, 1);
    chk_eq("one_done_cyc", 64'(done_cyc - t), 484);
    chk_eq("one_busy_at_done", busy_at_done, 0);
    chk_eq("one_busy_after", busy, 0);

    // Three frames, with a start pulse during the run that must be ignored.
    clr_mon();
    kick(8'd3, t);
    chk_eq("three_cnt_clr", frame_cnt, 0);
    step(300);
    num_frames = 8'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(2000);
    step(2);
    chk_eq("three_rises", n_rise, 3);
    chk_eq("three_hi_bad", hi_bad, 0);
    chk_eq("three_lo_n", lo_n, 2);
    chk_eq("three_lo_bad", lo_bad, 0);
    chk_eq("three_pix_bad", pix_bad, 0);
    chk_eq("three_de_count", n_de, 768);
    chk_eq("three_frame_cnt", frame_cnt, 3);
    chk_eq("three_done_cyc", 64'(done_cyc - t), 1446);
    chk_eq("three_done_cnt", n_done, 1);

    // Continuous run stopped on line 5 of frame 2.
    clr_mon();
    kick(8'd0, t);
    step(1089);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_done(1000);
    step(2);
    chk_eq("stop_frame_cnt", frame_cnt, 3);
    chk_eq("stop_de_count", n_de, 768);
    chk_eq("stop_pix_bad", pix_bad, 0);
    chk_eq("stop_de_bad", de_bad, 0);
    chk_eq("stop_done_cyc", 64'(done_cyc - t), 1446);
    chk_eq("stop_done_cnt", n_done, 1);

    // Stop while idle does nothing.
    clr_mon();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(600);
    chk_eq("idle_stop_done", n_done, 0);
    chk_eq("idle_stop_busy", busy, 0);
    chk_eq("idle_stop_vs", n_rise, 0);

    // Reset in the middle of frame 0, then a clean restart.
    clr_mon();
    kick(8'd1, t);
    step(52);
    chk_eq("pre_rst_vs", vga_vs, 1);
    vga_rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_outs", {vga_vs, vga_de, busy, rd_en}, 0);
    step(2);
    vga_rst_n = 1'b1;
    step(2);
    clr_mon();
    kick(8'd1, t);
    step(1);
    chk_eq("restart_rd_addr", rd_addr, 0);
    chk_eq("restart_rd_en", rd_en, 1);
    wait_done(600);
    step(2);
    chk_eq("restart_vs_rise", 64'(first_rise - t), 4);
    chk_eq("restart_de_count", n_de, 256);
    chk_eq("restart_de_bad", de_bad, 0);
    chk_eq("restart_done_cnt", n_done, 1);

`ifdef VGA_FRAME_SCHED_TESTPAT_EN
    // Test pattern ignores rd_data even when it is unknown.
    clr_mon();
    pat_en = 1'b1; mem_x = 1'b1;
    kick(8'd2, t);
    pat_en = 1'b0;
    wait_done(1200);
    step(2);
    mem_x = 1'b0;
    chk_eq("pat_pixel_f1_x3_y7", cap_pix, 32'h0001_0703);
    chk_eq("pat_de_count", n_de, 512);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_frame_sched.md
# vga_frame_sched

Frame scheduler and timing generator for the VGA-style pixel stream (`vga_vs`, `vga_de`, `vga_data`) used by the capture and logging path. It fetches pixels from a frame-source memory through a fixed-latency read port, re-times them into frames, and runs a bounded or continuous sequence of frames under start/stop control. Downstream consumers open a frame on `vga_vs` rising, take pixels while `vga_de` is high, and close the frame on `vga_vs` falling.

## Interface

Parameters:
- `H_ACT`, 16: active pixels per line.
- `V_ACT`, 16: active lines per frame.
- `H_BLANK`, 8: blank cycles after each active line.
- `V_BLANK`, 4: blank lines between frames (`vga_vs` low).
- `RD_LAT`, 2: source memory read latency in cycles, ≥1.
- `ADDR_W`, 8: read address width, ≥ clog2(H_ACT*V_ACT).
- `FRAME_W`, 8: frame counter width.

Ports:
- `vga_clk`  in  1: clock.
- `vga_rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to start a run; sampled only in IDLE.
- `stop`  in  1: one-cycle request to end the run after the current frame.
- `num_frames`  in  FRAME_W: frames per run, sampled on `start`; 0 = run until `stop`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse at the end of a run.
- `frame_cnt`  out  FRAME_W: frames completed in this run; cleared on accepted `start`.
- `rd_en`  out  1: read strobe to the source memory.
- `rd_addr`  out  ADDR_W: pixel address, `y*H_ACT+x`.
- `rd_data`  in  32: read data, valid `RD_LAT` cycles after `rd_en`.
- `vga_vs`  out  1: frame envelope, high for the whole active frame.
- `vga_de`  out  1: pixel valid.
- `vga_data`  out  32: pixel, `{8'h00,R,G,B}`.

## Operation

- FSM states:
  - IDLE
  - OPEN: 1 cycle, internal vs=1, no read.
  - ACT: `H_ACT` cycles, `rd_en`=1.
  - HBLK: `H_BLANK` cycles.
  - VBLK: `V_BLANK*(H_ACT+H_BLANK)` cycles, internal vs=0.
- Transitions:
  - IDLE→OPEN on `start`.
  - OPEN→ACT.
  - ACT→HBLK after x=H_ACT-1.
  - HBLK→ACT (next line) or →VBLK after line V_ACT-1.
  - VBLK→OPEN, or →IDLE with `done` if the run has ended.
- Internal vs is 1 in OPEN, ACT and HBLK; `frame_cnt` increments when the FSM enters VBLK.
- The run ends when `frame_cnt` reaches `num_frames` (if non-zero), or when `stop` has been latched. `stop` latches in any busy state and never truncates a frame; the frame in progress completes and its VBLK runs in full.
- `start` while busy is ignored. `stop` in IDLE is ignored.
- `rd_addr` counts 0..H_ACT*V_ACT-1 across the frame and resets to 0 in OPEN.
- `frame_cnt` wraps modulo 2^FRAME_W in continuous mode.

## Timing

- Reset value of every output is 0. Reset mid-frame returns the FSM to IDLE and drops `vga_vs` and `vga_de` asynchronously. Consumers see this as a truncated frame.
- Alignment: `vga_vs` and `vga_de` are the internal vs and `rd_en` delayed `RD_LAT+1` cycles. `vga_data` registers `rd_data` on the same cycle, so `vga_data` is valid in the cycle `vga_de` is high.
- On the `vga_vs` rising cycle, `vga_de` is always 0 (guaranteed by OPEN).
- With accepted `start` at cycle t:
  - `busy`=1 at t+1 and internal vs=1 at t+1.
  - First `rd_en` at t+2.
  - `vga_vs` rises at t+RD_LAT+2; first `vga_de` at t+RD_LAT+3.
- `done` pulses, and `busy` falls in the same cycle, on the last VBLK cycle plus `RD_LAT+1`, so that the delay line has drained.

## Configuration

- `VGA_FRAME_SCHED_TESTPAT_EN` defined: adds input `pat_en`, sampled on `start`.
  - With `pat_en`=1, `vga_data` = `{8'h00, frame_cnt[7:0], y[7:0], x[7:0]}`, pipelined with identical latency, and `rd_data` is ignored.
  - `rd_en` still toggles.
- Undefined: no `pat_en` port; `vga_data` always comes from `rd_data`.

## Structure

- Package `vga_frame_sched_pkg`:
  - FSM state enum.
  - Localparams `LINE_LEN` = H_ACT+H_BLANK, `FRAME_PIX` = H_ACT*V_ACT, `VBLK_LEN` = V_BLANK*LINE_LEN.
  - Pixel-packing function for the test pattern.
- Sub-module `vga_sched_delay`: parameterised width/depth shift register with async active-low reset. Used for the vs/de (and pattern) delay of depth `RD_LAT+1`.

## Test plan

- Reset asserted mid-ACT of frame 0 → `vga_vs`, `vga_de`, `busy`, `rd_en` = 0 immediately; FSM in IDLE; next `start` produces a clean frame from `rd_addr` 0.
- `num_frames`=1, defaults, memory returns `rd_data`=addr, `start` at t → `vga_vs` rises at t+4, first `vga_de` at t+5 with data 0. Exactly 256 `vga_de` cycles, data 0..255, 16 runs of 16 separated by 8-cycle gaps. `frame_cnt`=1; one `done` pulse; `busy` low after.
- `num_frames`=3 → three `vga_vs` high periods of 1+16*24=385 cycles, each separated by 96 low cycles; `frame_cnt` ends at 3.
- `num_frames`=0, `stop` pulsed at line 5 of frame 2 → frame 2 completes all 256 pixels; `done` follows that frame's VBLK; `frame_cnt`=3.
- `start` pulsed while `busy` → no effect on counts or timing. `stop` in IDLE → no `done`.
- With `VGA_FRAME_SCHED_TESTPAT_EN`, `pat_en`=1, 2 frames → frame 1 pixel (x=3,y=7) = 32'h0001_0703; `rd_data` forced to X has no effect on output.
